// File: rtl/encoder_8to3_pkg.sv
// Shared widths, mode encoding and helpers for the registered 8-to-3 encoder.
package encoder_8to3_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    MODE_STRICT   = 1'b0,
    MODE_PRIORITY = 1'b1
  } mode_e;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [IN_W-1:0] d);
    return |(d & (d - {{(IN_W-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational core: index of the highest set bit plus zero/multi-hot flags.
module encoder_8to3_core
  import encoder_8to3_pkg::*;
(
  input  logic [IN_W-1:0]  d,
  output logic [IDX_W-1:0] idx,
  output logic             any_set,
  output logic             multi_set
);

  // Ascending scan so the highest set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (d[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any_set   = |d;
  assign multi_set = popcount_gt1(d);

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 encoder: one-cycle latency, flags empty and multi-hot inputs.
module encoder_8to3
  import encoder_8to3_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] D,
  output logic            x,
  output logic            y,
  output logic            z,
  output logic            valid,
  output logic            err
);

  localparam mode_e MODE = (PRIORITY_MODE != 0) ? MODE_PRIORITY : MODE_STRICT;

  logic [IDX_W-1:0] idx;
  logic             any_set;
  logic             multi_set;
  logic             err_next;

  encoder_8to3_core u_core (
    .d         (D),
    .idx       (idx),
    .any_set   (any_set),
    .multi_set (multi_set)
  );

  // In priority mode a multi-hot word is a legal request, not an error.
  assign err_next = multi_set && (MODE == MODE_STRICT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= 1'b0;
      y     <= 1'b0;
      z     <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      {x, y, z} <= idx;
      valid     <= any_set;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: strict and priority instances share stimulus.
module tb_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] D;
  logic       x_s, y_s, z_s, valid_s, err_s;
  logic       x_p, y_p, z_p, valid_p, err_p;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  encoder_8to3 #(.PRIORITY_MODE(0)) dut_strict (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .x     (x_s),
    .y     (y_s),
    .z     (z_s),
    .valid (valid_s),
    .err   (err_s)
  );

  encoder_8to3 #(.PRIORITY_MODE(1)) dut_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .x     (x_p),
    .y     (y_p),
    .z     (z_p),
    .valid (valid_p),
    .err   (err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {x,y,z,valid,err} against a hand-computed expectation.
  task automatic check_output(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("[TB] FAIL %s: got xyz/valid/err=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [4:0] exp_s, input logic [4:0] exp_p);
    check_output({tag, "_strict"}, {x_s, y_s, z_s, valid_s, err_s}, exp_s);
    check_output({tag, "_prio"},   {x_p, y_p, z_p, valid_p, err_p}, exp_p);
  endtask

  task automatic apply_stimulus(input logic [7:0] value);
    D = value;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    D     = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check_both("reset_hold", 5'b000_0_0, 5'b000_0_0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < 8; j++) begin
      logic [7:0] one_hot;
      logic [2:0] j_idx;
      one_hot = 8'h01 << j;
      j_idx   = 3'(j);
      apply_stimulus(one_hot);
      check_both($sformatf("onehot_%0d", j), {j_idx, 2'b10}, {j_idx, 2'b10});
    end

    apply_stimulus(8'h00);
    check_both("zero", 5'b000_0_0, 5'b000_0_0);

    apply_stimulus(8'h41);
    check_both("multi_41", 5'b110_1_1, 5'b110_1_0);

    apply_stimulus(8'hFF);
    check_both("multi_FF", 5'b111_1_1, 5'b111_1_0);

    apply_stimulus(8'h0C);
    check_both("multi_0C", 5'b011_1_1, 5'b011_1_0);

    // D changes twice between edges; outputs must hold, then take the last value.
    D = 8'h02;
    #2;
    check_both("hold_mid", 5'b011_1_1, 5'b011_1_0);
    D = 8'h10;
    @(posedge clk);
    #1;
    check_both("latency_10", 5'b100_1_0, 5'b100_1_0);

    apply_stimulus(8'h80);
    check_both("pre_reset", 5'b111_1_0, 5'b111_1_0);

    #2;
    rst_n = 1'b0;
    #1;
    check_both("async_reset", 5'b000_0_0, 5'b000_0_0);
    @(posedge clk);
    #1;
    check_both("reset_edge", 5'b000_0_0, 5'b000_0_0);

    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(8'h80);
    check_both("post_reset", 5'b111_1_0, 5'b111_1_0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
